// File: rtl/ifw_pkg.sv
// Shared codes for the input-feature write path: master states, padding
// modes and the downstream write-FSM state codes.
package ifw_pkg;

    localparam logic [2:0] IW_IDLE = 3'd0;
    localparam logic [2:0] IW_DLOD = 3'd1;
    localparam logic [2:0] IW_WABF = 3'd2;
    localparam logic [2:0] IW_RST  = 3'd3;
    localparam logic [2:0] IW_DONE = 3'd4;

    localparam logic [2:0] LEFT   = 3'd1;
    localparam logic [2:0] NORMAL = 3'd2;
    localparam logic [2:0] RIGH   = 3'd3;

    localparam logic [2:0] WR_IDLE = 3'd0;
    localparam logic [2:0] WR_STG0 = 3'd1;
    localparam logic [2:0] WR_STG1 = 3'd2;
    localparam logic [2:0] WR_WAIT = 3'd3;
    localparam logic [2:0] WR_DONE = 3'd4;

endpackage

// File: rtl/ifw_wr_ctrl_count_yi_v4.sv
// Saturating up-counter: advances on en until it reaches final_number, then
// holds there; last flags that the count equals final_number.
module count_yi_v4 #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    input  logic [WIDTH-1:0] final_number,
    output logic             last,
    output logic [WIDTH-1:0] total_q
);

    assign last = (total_q == final_number);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            total_q <= '0;
        end else if (clear) begin
            total_q <= '0;
        end else if (en && !last) begin
            total_q <= total_q + 1'b1;
        end
    end

endmodule

// File: rtl/ifw_wr_ctrl.sv
// Master sequencer of the input-feature write path: issues FIFO reads, paces
// the packing counters, drains the write buffer, then clears and reports done.
module ifw_wr_ctrl
    import ifw_pkg::*;
#(
    parameter int CNT00_WIDTH   = 10,
    parameter int CNT01_WIDTH   = 10,
    parameter int WS_ADDR_WIDTH = 10,
    parameter int ROW_WIDTH     = 10,
    parameter int WABF_CYCLES   = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     abort,
    input  logic [2:0]               cfg_mode,
    input  logic [CNT00_WIDTH-1:0]   cfg_col_num,
    input  logic [CNT01_WIDTH-1:0]   cfg_ch_num,
    input  logic [ROW_WIDTH-1:0]     cfg_row_num,
    input  logic [WS_ADDR_WIDTH-1:0] cfg_srad_num,
    input  logic                     fifo_empty,
    output logic                     fifo_rd_en,
    input  logic                     wr_stg0_last,
    input  logic                     wr_stg1_last,
    output logic                     wr_stg0_en,
    output logic                     wr_stg1_en,
    output logic [CNT00_WIDTH-1:0]   wr_cnt00_finalnum,
    output logic [CNT01_WIDTH-1:0]   wr_cnt01_finalnum,
    output logic [WS_ADDR_WIDTH-1:0] wr_srad_finalnum,
    output logic                     din_idle2start,
    output logic                     din_row_last,
    output logic [2:0]               din_ifw_curr_state,
    output logic [2:0]               din_cfg_mast_state,
    output logic                     cnt_reset,
    output logic                     busy,
    output logic                     done,
    output logic                     cfg_err
);

    localparam int ISS_WIDTH = CNT00_WIDTH + CNT01_WIDTH + ROW_WIDTH;
    localparam int WABF_W    = $clog2(WABF_CYCLES + 1);

    logic [2:0]               state;
    logic [2:0]               next_state;
    logic [2:0]               mode_q;
    logic [CNT00_WIDTH-1:0]   col_fin_q;
    logic [CNT01_WIDTH-1:0]   ch_fin_q;
    logic [WS_ADDR_WIDTH-1:0] srad_fin_q;
    logic [ROW_WIDTH-1:0]     row_fin_q;
    logic [ISS_WIDTH-1:0]     iss_fin_q;
    logic [ISS_WIDTH-1:0]     iss_total;
    logic [ISS_WIDTH-1:0]     iss_cnt;
    logic [ROW_WIDTH-1:0]     row_cnt;
    logic [WABF_W-1:0]        wabf_cnt;
    logic                     rd_all;
    logic                     iss_last;
    logic                     row_last;
    logic                     row_end;
    logic                     in_idle;
    logic                     cfg_ok;
    logic                     ctr_clear;
    logic                     wabf_done;

    assign in_idle   = (state == IW_IDLE);
    assign cfg_ok    = (|cfg_col_num) & (|cfg_ch_num) & (|cfg_row_num) & (|cfg_srad_num);
    assign iss_total = ISS_WIDTH'(cfg_col_num) * ISS_WIDTH'(cfg_ch_num) * ISS_WIDTH'(cfg_row_num);
    assign wabf_done = (wabf_cnt == WABF_W'(WABF_CYCLES - 1));

    // Start decode is gated by reset so every output except cnt_reset reads 0 in reset.
    assign din_idle2start = reset & in_idle & start & cfg_ok;
    assign cfg_err        = reset & in_idle & start & ~cfg_ok;

    assign fifo_rd_en = (state == IW_DLOD) & ~fifo_empty & ~rd_all & ~abort;
    assign wr_stg1_en = wr_stg0_en & wr_stg0_last;
    assign row_end    = wr_stg0_en & wr_stg0_last & wr_stg1_last;

    assign cnt_reset = ~reset | (state == IW_RST);
    assign ctr_clear = cnt_reset | din_idle2start;

    assign din_ifw_curr_state = state;
    assign din_cfg_mast_state = in_idle ? (reset ? cfg_mode : 3'd0) : mode_q;
    assign din_row_last       = (state == IW_DLOD) & row_last;
    assign busy               = ~in_idle;
    assign done               = (state == IW_DONE);

    assign wr_cnt00_finalnum = col_fin_q;
    assign wr_cnt01_finalnum = ch_fin_q;
    assign wr_srad_finalnum  = srad_fin_q;

    count_yi_v4 #(.WIDTH(ISS_WIDTH)) u_issue_cnt (
        .clk          (clk),
        .reset        (reset),
        .clear        (ctr_clear),
        .en           (fifo_rd_en),
        .final_number (iss_fin_q),
        .last         (iss_last),
        .total_q      (iss_cnt)
    );

    count_yi_v4 #(.WIDTH(ROW_WIDTH)) u_row_cnt (
        .clk          (clk),
        .reset        (reset),
        .clear        (ctr_clear),
        .en           (row_end),
        .final_number (row_fin_q),
        .last         (row_last),
        .total_q      (row_cnt)
    );

    // Leaving DLOD waits for the trailing registered write after the last read.
    always_comb begin
        next_state = state;
        case (state)
            IW_IDLE: if (din_idle2start) next_state = IW_DLOD;
            IW_DLOD: begin
                if (abort)                    next_state = IW_RST;
                else if (rd_all && !wr_stg0_en) next_state = IW_WABF;
            end
            IW_WABF: begin
                if (abort)          next_state = IW_RST;
                else if (wabf_done) next_state = IW_RST;
            end
            IW_RST:  next_state = IW_DONE;
            IW_DONE: next_state = IW_IDLE;
            default: next_state = IW_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IW_IDLE;
            wr_stg0_en <= 1'b0;
            rd_all     <= 1'b0;
            wabf_cnt   <= '0;
        end else begin
            state      <= next_state;
            wr_stg0_en <= fifo_rd_en;
            wabf_cnt   <= (state == IW_WABF) ? wabf_cnt + 1'b1 : '0;
            if (ctr_clear) begin
                rd_all <= 1'b0;
            end else if (fifo_rd_en && iss_last) begin
                rd_all <= 1'b1;
            end
        end
    end

    // Job parameters are frozen at start so mid-job cfg changes are invisible.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_q     <= '0;
            col_fin_q  <= '0;
            ch_fin_q   <= '0;
            srad_fin_q <= '0;
            row_fin_q  <= '0;
            iss_fin_q  <= '0;
        end else if (din_idle2start) begin
            mode_q     <= cfg_mode;
            col_fin_q  <= cfg_col_num - 1'b1;
            ch_fin_q   <= cfg_ch_num - 1'b1;
            srad_fin_q <= cfg_srad_num - 1'b1;
            row_fin_q  <= cfg_row_num - 1'b1;
            iss_fin_q  <= iss_total - 1'b1;
        end
    end

endmodule

// File: doc/ifw_wr_ctrl.md
Name: ifw_wr_ctrl

Overview:
- Master sequencer for the input-feature write path: drives the packing counter / write-FSM block (stage-0/1 enables, final numbers, padding mode, idle-to-start, row-last, master state).
- Pulls data from the input FIFO, counts rows, waits for the write buffer to drain, clears the counters and reports done.
- Sits between the top-level layer configuration/start logic and the write-buffer counter block.

Parameters:
- CNT00_WIDTH, 10, width of stage-0 (column) count and final number.
- CNT01_WIDTH, 10, width of stage-1 (channel) count and final number.
- WS_ADDR_WIDTH, 10, width of SRAM address final number.
- ROW_WIDTH, 10, width of row count.
- WABF_CYCLES, 4, buffer-drain wait length in IW_WABF (must be 1 or more).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle job start, sampled in IW_IDLE only.
- abort  in  1  synchronous abort.
- cfg_mode  in  3  padding mode: 1 = LEFT, 2 = NORMAL, 3 = RIGH.
- cfg_col_num  in  CNT00_WIDTH  columns per channel.
- cfg_ch_num  in  CNT01_WIDTH  channels per row.
- cfg_row_num  in  ROW_WIDTH  rows per job.
- cfg_srad_num  in  WS_ADDR_WIDTH  SRAM words per row.
- fifo_empty  in  1  input FIFO empty.
- fifo_rd_en  out  1  FIFO pop; data is valid one cycle later.
- wr_stg0_last  in  1  stage-0 counter at final value.
- wr_stg1_last  in  1  stage-1 counter at final value.
- wr_stg0_en  out  1  stage-0 / SRAM-address counter enable.
- wr_stg1_en  out  1  stage-1 counter enable.
- wr_cnt00_finalnum  out  CNT00_WIDTH  final stage-0 count.
- wr_cnt01_finalnum  out  CNT01_WIDTH  final stage-1 count.
- wr_srad_finalnum  out  WS_ADDR_WIDTH  final SRAM-address count.
- din_idle2start  out  1  job-start strobe to the write FSM.
- din_row_last  out  1  current row is the last row.
- din_ifw_curr_state  out  3  IW state code.
- din_cfg_mast_state  out  3  padding mode.
- cnt_reset  out  1  active-high synchronous clear for the counter block.
- busy  out  1  state is not IW_IDLE.
- done  out  1  one-cycle job-complete pulse.
- cfg_err  out  1  one-cycle pulse: start was rejected.

Behaviour:
- Reset (reset = 0): state IW_IDLE; all registers cleared; every output 0 except cnt_reset, which is 1 while reset is low (combinational).
- States: IW_IDLE = 0, IW_DLOD = 1, IW_WABF = 2, IW_RST = 3, IW_DONE = 4. din_ifw_curr_state is the registered state.
- IW_IDLE:
  - din_idle2start = start & all cfg counts nonzero (combinational).
  - din_cfg_mast_state = cfg_mode, passed through so the write FSM sees it in the same cycle.
  - On din_idle2start: latch cfg_mode; latch every final number as its cfg value - 1; clear row and issue counters; go to IW_DLOD.
  - start with any count zero: cfg_err pulses, state stays IW_IDLE, no din_idle2start.
- Outside IW_IDLE, din_cfg_mast_state and the final numbers come from the latched values. A mid-job cfg change has no effect.
- IW_DLOD:
  - fifo_rd_en = ~fifo_empty & ~rd_all.
  - Issue counter has width CNT00_WIDTH + CNT01_WIDTH + ROW_WIDTH and compares against col*ch*row. rd_all sets when the last read is issued.
  - wr_stg0_en = fifo_rd_en delayed by one register.
  - wr_stg1_en = wr_stg0_en & wr_stg0_last.
  - Row end = wr_stg0_en & wr_stg0_last & wr_stg1_last. The row counter increments on row end and holds at its final value.
  - din_row_last = (row_cnt == row_final).
  - Go to IW_WABF when rd_all & ~wr_stg0_en, i.e. the last write has been accepted.
- IW_WABF: hold for WABF_CYCLES cycles with all enables 0, then go to IW_RST.
- IW_RST: cnt_reset = 1 for exactly one cycle; clear internal counters; go to IW_DONE.
- IW_DONE: done = 1 for one cycle; go to IW_IDLE. A start arriving in IW_DONE is ignored.
- abort in IW_DLOD or IW_WABF:
  - Next state IW_RST.
  - fifo_rd_en is forced to 0 in the abort cycle.
  - An in-flight wr_stg0_en still completes. It is the registered read from the previous cycle and the data is discarded downstream.
  - abort in IW_IDLE, IW_RST or IW_DONE is ignored.
- Simultaneous row end and rd_all: the row counter increments and the WABF transition still waits for ~wr_stg0_en.
- fifo_empty toggling mid-row only stalls; counters do not advance without wr_stg0_en.
- Asynchronous reset mid-job returns immediately to reset values; no done pulse.

Decomposition:
- Shared package ifw_pkg:
  - IW_* state codes.
  - Padding-mode codes LEFT = 1, NORMAL = 2, RIGH = 3.
  - Write-FSM codes WR_IDLE..WR_DONE.
- Sub-module: the row counter and the issue counter each reuse count_yi_v4 (final_number / last / total_q), cleared by cnt_reset. No new sub-module.

Test Plan:
- NORMAL job: col = 4, ch = 2, row = 3, FIFO never empty -> 24 fifo_rd_en cycles; wr_stg1_en pulses 6 times; din_row_last high during row 3; after the last write, 4 IW_WABF cycles, 1 cnt_reset cycle, then done one cycle later.
- Final-number latch: LEFT job with col = 3, ch = 1, row = 2, cfg changed mid-job -> din_idle2start and din_cfg_mast_state = 1 in the start cycle; finalnum outputs stay 2 / 0 / srad - 1 for the whole job.
- FIFO stalls: fifo_empty high on alternating cycles -> exactly col*ch*row reads total; wr_stg0_en always equals fifo_rd_en delayed one cycle; no extra reads after rd_all.
- Zero config: start with cfg_row_num = 0 -> cfg_err pulse, no din_idle2start, busy stays 0.
- Abort: abort asserted at read 5 of 24 -> next state IW_RST, cnt_reset one cycle, done, IW_IDLE; no further fifo_rd_en.
- Async reset: reset low in IW_WABF -> all outputs 0 and cnt_reset = 1 immediately; after release, a new start runs a full job correctly.
